// File: rtl/pulse_filter_pkg.sv
// Shared types for the pulse filter: FSM states and edge_sel_i encodings.
package pulse_filter_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  // True when a committed edge of the given direction should strobe pulse_o.
  function automatic logic edge_hit(input logic [1:0] sel, input logic rising);
    return (sel == EDGE_BOTH) || (rising ? (sel == EDGE_RISE) : (sel == EDGE_FALL));
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ff <= '0;
    else          ff <= {ff[STAGES-2:0], d_i};
  end

  assign q_o = ff[STAGES-1];

endmodule

// File: rtl/pulse_filter.sv
// Debounce filter with edge strobe; glitch counter built only when
// PULSE_FILTER_GLITCH_CNT_EN is defined, otherwise glitch_cnt_o reads 0.
module pulse_filter
  import pulse_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sig_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [1:0]        edge_sel_i,
  output logic              level_o,
  output logic              pulse_o,
  output logic [7:0]        glitch_cnt_o
);

  logic              sync;
  state_t            state_q, state_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic              glitch_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (sig_i),
    .q_o     (sync)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Counter only advances while below the live threshold, so it cannot wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    pulse_d    = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      LOW: if (sync) begin
        state_d = CHK_HIGH;
        cnt_d   = '0;
      end
      HIGH: if (!sync) begin
        state_d = CHK_LOW;
        cnt_d   = '0;
      end
      CHK_HIGH: begin
        if (sync) begin
          if (cnt_q >= filt_len_i) begin
            state_d = HIGH;
            level_d = 1'b1;
            pulse_d = edge_hit(edge_sel_i, 1'b1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d    = LOW;
          glitch_inc = 1'b1;
        end
      end
      CHK_LOW: begin
        if (!sync) begin
          if (cnt_q >= filt_len_i) begin
            state_d = LOW;
            level_d = 1'b0;
            pulse_d = edge_hit(edge_sel_i, 1'b0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d    = HIGH;
          glitch_inc = 1'b1;
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

`ifdef PULSE_FILTER_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                           glitch_q <= 8'h00;
    else if (glitch_inc && glitch_q != 8'hff) glitch_q <= glitch_q + 8'd1;
  end

  assign glitch_cnt_o = glitch_q;
`else
  logic glitch_unused;
  assign glitch_unused = glitch_inc;
  assign glitch_cnt_o  = 8'h00;
`endif

endmodule

// File: tb/tb_pulse_filter.sv
// Scoreboard bench for pulse_filter: stimulus queues expected level/pulse
// events with their commit cycle; a negedge monitor pops and compares.
module tb_pulse_filter;

  localparam int S  = 2;
  localparam int FW = 8;

  typedef struct {
    int   cyc;
    logic lvl;
    logic pls;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig = 1'b0;
  logic [FW-1:0] filt = 8'd3;
  logic [1:0]    esel = 2'b00;
  logic          level_o, pulse_o;
  logic [7:0]    glitch_cnt_o;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gl = 0;
  int   pulse_seen = 0;
  logic prev_lvl = 1'b0;
  logic prev_pls = 1'b0;
  ev_t  exp_q[$];

  pulse_filter #(.SYNC_STAGES(S), .FILT_W(FW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .sig_i        (sig),
    .filt_len_i   (filt),
    .edge_sel_i   (esel),
    .level_o      (level_o),
    .pulse_o      (pulse_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: any level change or strobe must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (level_o !== prev_lvl || pulse_o === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d level=%0b pulse=%0b", cyc, level_o, pulse_o);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || level_o !== e.lvl || pulse_o !== e.pls) begin
          failures++;
          $display("FAIL event got cyc=%0d level=%0b pulse=%0b want cyc=%0d level=%0b pulse=%0b",
                   cyc, level_o, pulse_o, e.cyc, e.lvl, e.pls);
        end
      end
    end
    if (pulse_o === 1'b1) begin
      checks++;
      pulse_seen++;
      if (prev_pls) begin
        failures++;
        $display("FAIL pulse_width cyc=%0d pulse high two cycles", cyc);
      end
    end
    prev_lvl = level_o;
    prev_pls = pulse_o;
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic int gexp();
`ifdef PULSE_FILTER_GLITCH_CNT_EN
    return (gl > 255) ? 255 : gl;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new level and queue its expected commit (edge 1 = next posedge).
  task automatic drive(input logic v, input int f, input logic pls);
    ev_t e;
    sig = v;
    e.cyc = cyc + S + f + 2;
    e.lvl = v;
    e.pls = pls;
    exp_q.push_back(e);
  endtask

  initial begin
    int p0;
    // Reset state
    #2;
    chk("rst_level", level_o, 0);
    chk("rst_pulse", pulse_o, 0);
    chk("rst_glitch", glitch_cnt_o, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Rising commit on edge 7 with filt 3, then falling with rise-only select
    filt = 8'd3; esel = 2'b00;
    drive(1'b1, 3, 1'b1);
    tick(20);
    chk("rise_level", level_o, 1);
    chk("rise_glitch", glitch_cnt_o, 0);
    drive(1'b0, 3, 1'b0);
    tick(20);
    chk("fall_level", level_o, 0);

    // Short high burst rejected
    filt = 8'd5;
    sig = 1'b1;
    tick(3);
    sig = 1'b0;
    gl++;
    tick(20);
    chk("reject_level", level_o, 0);
    chk("reject_glitch", glitch_cnt_o, gexp());

    // Edge select none: level tracks, no strobes
    filt = 8'd2; esel = 2'b11;
    drive(1'b1, 2, 1'b0);
    tick(20);
    drive(1'b0, 2, 1'b0);
    tick(20);
    chk("none_level", level_o, 0);

    // Both edges, filt 0: 10 square waves of period 40
    filt = 8'd0; esel = 2'b10;
    p0 = pulse_seen;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 0, 1'b1);
      tick(20);
      drive(1'b0, 0, 1'b1);
      tick(20);
    end
    chk("both_pulse_count", pulse_seen - p0, 20);

    // Threshold lowered mid-check commits early; falling select
    esel = 2'b01; filt = 8'd10;
    drive(1'b1, 1, 1'b0);
    tick(3);
    filt = 8'd1;
    tick(20);
    chk("midcheck_level", level_o, 1);
    drive(1'b0, 1, 1'b1);
    tick(20);

    // Reset during CHK_HIGH aborts; sig still high refilters after release
    esel = 2'b00; filt = 8'd3;
    sig = 1'b1;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    gl = 0;
    chk("midrst_level", level_o, 0);
    chk("midrst_pulse", pulse_o, 0);
    chk("midrst_glitch", glitch_cnt_o, 0);
    tick(3);
    rst_n = 1'b1;
    begin
      ev_t e;
      e.cyc = cyc + S + 3 + 2;
      e.lvl = 1'b1;
      e.pls = 1'b1;
      exp_q.push_back(e);
    end
    tick(20);
    chk("postrst_level", level_o, 1);
    drive(1'b0, 3, 1'b0);
    tick(20);

    // 300 two-cycle glitches saturate the counter
    filt = 8'd4;
    for (int i = 0; i < 300; i++) begin
      sig = 1'b1;
      tick(2);
      sig = 1'b0;
      tick(4);
      gl++;
    end
    tick(10);
    chk("sat_glitch", glitch_cnt_o, gexp());
    chk("sat_level", level_o, 0);

    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_filter.md
PULSE_FILTER -- requirements
Module: pulse_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_i (legal range 2..4).
REQ-002 SHALL have parameter FILT_W, default 8, width of the stability counter and of filt_len_i.
REQ-003 SHALL have port clk_i  input  1  system clock (200 MHz).
REQ-004 SHALL have port rst_n_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port sig_i  input  1  raw external pulse signal, asynchronous to clk_i.
REQ-006 SHALL have port filt_len_i  input  FILT_W  extra stable cycles required before a transition is accepted.
REQ-007 SHALL have port edge_sel_i  input  2  pulse edge select: 00 rising, 01 falling, 10 both, 11 none.
REQ-008 SHALL have port level_o  output  1  filtered, debounced level of sig_i.
REQ-009 SHALL have port pulse_o  output  1  single-cycle strobe per accepted selected edge; drives the pulse counter's pulse_i.
REQ-010 SHALL have port glitch_cnt_o  output  8  saturating count of rejected transitions.

Function
REQ-011 SHALL pass sig_i through a SYNC_STAGES flop chain; only the last stage (sync) feeds the logic below.
REQ-012 SHALL implement FSM states LOW, CHK_HIGH, HIGH, CHK_LOW.
REQ-013 LOW: sync=1 -> CHK_HIGH with counter cleared to 0; else stay.
REQ-014 HIGH: sync=0 -> CHK_LOW with counter cleared to 0; else stay.
REQ-015 CHK_x, sync equals target level: counter >= filt_len_i -> commit (go to HIGH/LOW, update level_o); else counter +1.
REQ-016 CHK_x, sync differs from target: reject, return to previous stable state, no level_o change, glitch counter +1.
REQ-017 Counter SHALL never wrap; compare against live filt_len_i each cycle, so a mid-check decrease below counter commits on the next matching cycle.
REQ-018 filt_len_i=0 SHALL accept a transition after one matching cycle in CHK_x.
REQ-019 level_o and pulse_o SHALL change on the (SYNC_STAGES + filt_len_i + 2)th rising clk_i edge, counting the edge that first samples the new sig_i level as edge 1.
REQ-020 pulse_o SHALL be registered, high exactly one cycle, coincident with the level_o update, only when the committed edge matches edge_sel_i; never high two consecutive cycles.
REQ-021 edge_sel_i SHALL be evaluated at commit time; 11 suppresses pulse_o but level_o still tracks.
REQ-022 glitch_cnt_o SHALL saturate at 8'hff.

Reset
REQ-023 On rst_n_i low: sync chain 0, state LOW, counter 0, level_o 0, pulse_o 0, glitch_cnt_o 0, immediately and asynchronously.
REQ-024 sig_i already high at reset release SHALL be treated as a rising transition and filtered normally.
REQ-025 Reset asserted mid-check SHALL abort the check with no pulse_o emitted.

Configuration
REQ-026 Macro PULSE_FILTER_GLITCH_CNT_EN defined: glitch counter implemented per REQ-016/REQ-022.
REQ-027 Macro undefined: no glitch counter flops; glitch_cnt_o tied to 8'h00; filtering and pulse behaviour unchanged.

Structure
REQ-028 Package pulse_filter_pkg SHALL hold the FSM state enum and the edge_sel_i encoding constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE).
REQ-029 The synchronizer chain SHALL be a sub-module sync_ff, parameterised by stage count, with the same clock and reset.

Verification
REQ-030 filt_len_i=3, edge_sel_i=00, SYNC_STAGES=2, sig_i 0->1 held 20 cycles -> level_o and pulse_o rise on edge 7; pulse_o width 1; glitch_cnt_o 0.
REQ-031 filt_len_i=5, sig_i high for 3 cycles then low -> level_o stays 0, no pulse_o, glitch_cnt_o=1.
REQ-032 edge_sel_i=10, filt_len_i=0, 10 clean 40-cycle-period square waves -> 20 pulse_o strobes; a downstream 1 s pulse counter reads 20.
REQ-033 300 rejected 2-cycle glitches with filt_len_i=4 -> glitch_cnt_o=8'hff, no wrap; without PULSE_FILTER_GLITCH_CNT_EN -> 8'h00.
REQ-034 rst_n_i pulsed low in CHK_HIGH -> all outputs 0 asynchronously, no pulse_o; sig_i still high after release -> rising pulse after filter latency.
REQ-035 edge_sel_i=11, full high/low cycle -> level_o toggles twice, pulse_o never asserts.
